// File: rtl/sim_mem_bridge_if.sv
// Bus bundle for sim_mem_bridge: LSU data port, RAM data port, console stream and halt status.
// The master modport is the LSU/console/RAM side; the slave modport is the bridge itself.
interface sim_mem_bridge_if;
   logic        lsu_ce_i;
   logic        lsu_we_i;
   logic [31:0] lsu_addr_i;
   logic [3:0]  lsu_sel_i;
   logic [31:0] lsu_data_i;
   logic [31:0] lsu_data_o;
   logic        lsu_stall_o;
   logic        ram_ce_o;
   logic        ram_we_o;
   logic [31:0] ram_addr_o;
   logic [3:0]  ram_sel_o;
   logic [31:0] ram_data_o;
   logic [31:0] ram_data_i;
   logic        char_valid_o;
   logic [7:0]  char_data_o;
   logic        char_ready_i;
   logic        sim_halt_o;
   logic [7:0]  sim_exit_code_o;

   modport master (
      output lsu_ce_i, lsu_we_i, lsu_addr_i, lsu_sel_i, lsu_data_i,
      input  lsu_data_o, lsu_stall_o,
      input  ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o,
      output ram_data_i,
      input  char_valid_o, char_data_o,
      output char_ready_i,
      input  sim_halt_o, sim_exit_code_o
   );

   modport slave (
      input  lsu_ce_i, lsu_we_i, lsu_addr_i, lsu_sel_i, lsu_data_i,
      output lsu_data_o, lsu_stall_o,
      output ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o,
      input  ram_data_i,
      output char_valid_o, char_data_o,
      input  char_ready_i,
      output sim_halt_o, sim_exit_code_o
   );
endinterface

// File: rtl/sim_mem_bridge.sv
// LSU-to-RAM bridge with simulation MMIO: char-out FIFO, sim-control halt sequencing.
// Optional `SIM_MEM_BRIDGE_CYCLE_CNT_EN adds a 64-bit RUN-cycle counter readable at 0x20004/0x20008.
module sim_mem_bridge #(
   parameter int          FIFO_DEPTH    = 8,
   parameter logic [31:0] CHAR_OUT_ADDR = 32'h00020000,
   parameter logic [31:0] SIM_CTRL_ADDR = 32'h00020002
) (
   input  logic             clk_i,
   input  logic             rst_i,
   sim_mem_bridge_if.slave  bus
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t           state, state_nxt;
   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic [7:0]       exit_code;

   logic        running;
   logic        mmio_word;
   logic        is_mmio;
   logic        char_wr;
   logic        ctrl_wr;
   logic        full;
   logic        push;
   logic        pop;
   logic        ctrl_acc;
   logic [31:0] mmio_rdata;

   assign running   = (state == RUN);
   assign mmio_word = (bus.lsu_addr_i[31:2] == CHAR_OUT_ADDR[31:2]) ||
                      (bus.lsu_addr_i[31:2] == SIM_CTRL_ADDR[31:2]);
   assign char_wr   = bus.lsu_ce_i && bus.lsu_we_i && (bus.lsu_addr_i == CHAR_OUT_ADDR);
   assign ctrl_wr   = bus.lsu_ce_i && bus.lsu_we_i && (bus.lsu_addr_i == SIM_CTRL_ADDR);
   assign full      = (count == FULL_CNT);

`ifdef SIM_MEM_BRIDGE_CYCLE_CNT_EN
   localparam logic [31:0] CNT_LO_ADDR = 32'h00020004;
   localparam logic [31:0] CNT_HI_ADDR = 32'h00020008;

   logic [63:0] cycle_cnt;
   logic        cnt_lo_hit;
   logic        cnt_hi_hit;

   assign cnt_lo_hit = (bus.lsu_addr_i[31:2] == CNT_LO_ADDR[31:2]);
   assign cnt_hi_hit = (bus.lsu_addr_i[31:2] == CNT_HI_ADDR[31:2]);
   assign is_mmio    = mmio_word || cnt_lo_hit || cnt_hi_hit;

   always_comb begin
      mmio_rdata = 32'h0;
      if (cnt_lo_hit)      mmio_rdata = cycle_cnt[31:0];
      else if (cnt_hi_hit) mmio_rdata = cycle_cnt[63:32];
   end

   // Counter freezes as soon as the halt sequence begins.
   always_ff @(posedge clk_i) begin
      if (rst_i)        cycle_cnt <= 64'h0;
      else if (running) cycle_cnt <= cycle_cnt + 64'(1);
   end
`else
   assign is_mmio    = mmio_word;
   assign mmio_rdata = 32'h0;
`endif

   // Accepted-access qualifiers; stall depends only on the registered count.
   assign push     = char_wr && running && !full;
   assign pop      = bus.char_valid_o && bus.char_ready_i;
   assign ctrl_acc = ctrl_wr && running;

   always_comb begin
      bus.lsu_stall_o = 1'b0;
      if (bus.lsu_ce_i && (!running || (char_wr && full)))
         bus.lsu_stall_o = 1'b1;
   end

   assign bus.ram_ce_o   = bus.lsu_ce_i && running && !is_mmio;
   assign bus.ram_we_o   = bus.lsu_we_i;
   assign bus.ram_addr_o = bus.lsu_addr_i;
   assign bus.ram_sel_o  = bus.lsu_sel_i;
   assign bus.ram_data_o = bus.lsu_data_i;
   assign bus.lsu_data_o = is_mmio ? mmio_rdata : bus.ram_data_i;

   // Char-out FIFO: storage carries no reset, pointers and count do.
   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr] <= bus.lsu_data_i[7:0];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign bus.char_valid_o = (count != '0);
   assign bus.char_data_o  = bus.char_valid_o ? fifo_mem[rd_ptr] : 8'h00;

   // Halt sequencer.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= RUN;
         exit_code <= 8'h00;
      end else begin
         state <= state_nxt;
         if (ctrl_acc) exit_code <= bus.lsu_data_i[7:0];
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (ctrl_acc) state_nxt = DRAIN;
         DRAIN:   if (count == '0) state_nxt = HALTED;
         HALTED:  state_nxt = HALTED;
         default: state_nxt = RUN;
      endcase
   end

   assign bus.sim_halt_o      = (state == HALTED);
   assign bus.sim_exit_code_o = exit_code;

endmodule

// File: tb/tb_sim_mem_bridge.sv
// Scoreboard bench for sim_mem_bridge: RAM pass-through, char-out FIFO, halt drain, reset, cycle counter.
module tb_sim_mem_bridge;
   localparam logic [31:0] CHAR_ADDR = 32'h00020000;
   localparam logic [31:0] CTRL_ADDR = 32'h00020002;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [7:0]  exp_q [$];
   logic [31:0] ram [256];

   always #5 clk = ~clk;

   sim_mem_bridge_if bif();

   sim_mem_bridge dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bif.slave)
   );

   // Simple RAM: combinational read, byte-lane write on the clock edge.
   always_comb bif.ram_data_i = ram[bif.ram_addr_o[9:2]];

   always @(posedge clk) begin
      if (bif.ram_ce_o && bif.ram_we_o)
         for (int b = 0; b < 4; b++)
            if (bif.ram_sel_o[b]) ram[bif.ram_addr_o[9:2]][b*8 +: 8] <= bif.ram_data_o[b*8 +: 8];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Console monitor: every pop is compared against the oldest expected byte.
   always @(negedge clk) begin
      if (!rst && bif.char_valid_o && bif.char_ready_i) begin
         if (exp_q.size() == 0) check("char_unexpected", 1, 0);
         else check("char_data", bif.char_data_o, exp_q.pop_front());
      end
   end

   // Called at posedge+1; returns at posedge+1 after the access is accepted.
   task automatic lsu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic exp_ram);
      int n = 0;
      bif.lsu_ce_i = 1'b1; bif.lsu_we_i = 1'b1;
      bif.lsu_addr_i = a;  bif.lsu_data_i = d; bif.lsu_sel_i = s;
      @(negedge clk);
      while (bif.lsu_stall_o && n < 50) begin n++; @(negedge clk); end
      if (n >= 50) check("wr_timeout", 0, 1);
      check("wr_ram_ce", bif.ram_ce_o, exp_ram);
      if (a == CHAR_ADDR) exp_q.push_back(d[7:0]);
      @(posedge clk); #1;
      bif.lsu_ce_i = 1'b0; bif.lsu_we_i = 1'b0;
   endtask

   task automatic lsu_read(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_ram);
      bif.lsu_ce_i = 1'b1; bif.lsu_we_i = 1'b0;
      bif.lsu_addr_i = a;  bif.lsu_sel_i = 4'hF;
      @(negedge clk);
      check("rd_stall", bif.lsu_stall_o, 0);
      check("rd_data", bif.lsu_data_o, exp_d);
      check("rd_ram_ce", bif.ram_ce_o, exp_ram);
      @(posedge clk); #1;
      bif.lsu_ce_i = 1'b0;
   endtask

   task automatic wait_empty(input string tag);
      int n = 0;
      @(negedge clk);
      while (bif.char_valid_o && n < 40) begin n++; @(negedge clk); end
      check(tag, bif.char_valid_o, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 32'h0;
      bif.lsu_ce_i = 1'b0; bif.lsu_we_i = 1'b0; bif.lsu_addr_i = 32'h0;
      bif.lsu_sel_i = 4'h0; bif.lsu_data_i = 32'h0; bif.char_ready_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_char_valid", bif.char_valid_o, 0);
      check("rst_char_data", bif.char_data_o, 8'h00);
      check("rst_halt", bif.sim_halt_o, 0);
      check("rst_exit", bif.sim_exit_code_o, 8'h00);
      check("rst_stall", bif.lsu_stall_o, 0);
      @(posedge clk); #1;

      // RAM pass-through and MMIO decode.
      lsu_write(32'h100, 32'hDEADBEEF, 4'hF, 1'b1);
      lsu_read(32'h100, 32'hDEADBEEF, 1'b1);
      lsu_write(32'h104, 32'h11223344, 4'b0101, 1'b1);
      lsu_read(32'h104, 32'h00220044, 1'b1);
      lsu_read(CHAR_ADDR, 32'h0, 1'b0);
      lsu_read(32'h00020001, 32'h0, 1'b0);
      lsu_write(32'h00020001, 32'h55, 4'hF, 1'b0);
      @(negedge clk);
      check("dropped_wr", bif.char_valid_o, 0);
      @(posedge clk); #1;

      // Char-out ordering with a ready console.
      bif.char_ready_i = 1'b1;
      lsu_write(CHAR_ADDR, 32'h48, 4'h1, 1'b0);
      lsu_write(CHAR_ADDR, 32'h69, 4'h1, 1'b0);
      wait_empty("hi_drained");

      // Full FIFO: 8 accepted, 9th stalls until one pop frees a slot.
      bif.char_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) lsu_write(CHAR_ADDR, 32'h30 + i, 4'h1, 1'b0);
      bif.lsu_ce_i = 1'b1; bif.lsu_we_i = 1'b1;
      bif.lsu_addr_i = CHAR_ADDR; bif.lsu_data_i = 32'h39;
      @(negedge clk);
      check("full_stall", bif.lsu_stall_o, 1);
      check("full_head", bif.char_data_o, 8'h30);
      @(posedge clk); #1 bif.char_ready_i = 1'b1;
      @(negedge clk);
      check("full_stall_pop", bif.lsu_stall_o, 1);
      @(posedge clk); #1 bif.char_ready_i = 1'b0;
      @(negedge clk);
      check("full_accept", bif.lsu_stall_o, 0);
      exp_q.push_back(8'h39);
      @(posedge clk); #1;
      @(negedge clk);
      check("full_again", bif.lsu_stall_o, 1);
      check("full_head2", bif.char_data_o, 8'h31);
      @(posedge clk); #1;
      bif.lsu_ce_i = 1'b0; bif.lsu_we_i = 1'b0;
      bif.char_ready_i = 1'b1;
      wait_empty("full_drained");
      check("full_q_empty", exp_q.size(), 0);

      // Halt with three bytes still buffered.
      bif.char_ready_i = 1'b0;
      lsu_write(CHAR_ADDR, 32'h61, 4'h1, 1'b0);
      lsu_write(CHAR_ADDR, 32'h62, 4'h1, 1'b0);
      lsu_write(CHAR_ADDR, 32'h63, 4'h1, 1'b0);
      lsu_write(CTRL_ADDR, 32'h2A, 4'h1, 1'b0);
      bif.lsu_ce_i = 1'b1; bif.lsu_we_i = 1'b0; bif.lsu_addr_i = 32'h100;
      @(negedge clk);
      check("drain_halt", bif.sim_halt_o, 0);
      check("drain_exit", bif.sim_exit_code_o, 8'h2A);
      check("drain_stall", bif.lsu_stall_o, 1);
      check("drain_ram_ce", bif.ram_ce_o, 0);
      @(posedge clk); #1;
      bif.lsu_we_i = 1'b1; bif.lsu_addr_i = CTRL_ADDR; bif.lsu_data_i = 32'h55;
      bif.char_ready_i = 1'b1;
      begin
         int n = 0;
         @(negedge clk);
         while (bif.char_valid_o && n < 20) begin n++; @(negedge clk); end
         check("drain_done", bif.char_valid_o, 0);
      end
      check("halt_latency", bif.sim_halt_o, 0);
      @(negedge clk);
      check("halt", bif.sim_halt_o, 1);
      check("halt_exit", bif.sim_exit_code_o, 8'h2A);
      check("halt_stall", bif.lsu_stall_o, 1);
      @(posedge clk); #1;
      bif.lsu_ce_i = 1'b0; bif.lsu_we_i = 1'b0;
      check("halt_q_empty", exp_q.size(), 0);

      // Reset in the middle of a drain.
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      bif.char_ready_i = 1'b0;
      lsu_write(CHAR_ADDR, 32'h71, 4'h1, 1'b0);
      lsu_write(CHAR_ADDR, 32'h72, 4'h1, 1'b0);
      lsu_write(CTRL_ADDR, 32'h11, 4'h1, 1'b0);
      @(negedge clk);
      check("pre_rst_valid", bif.char_valid_o, 1);
      check("pre_rst_halt", bif.sim_halt_o, 0);
      @(posedge clk); #1 rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("mid_rst_valid", bif.char_valid_o, 0);
      check("mid_rst_data", bif.char_data_o, 8'h00);
      check("mid_rst_halt", bif.sim_halt_o, 0);
      check("mid_rst_exit", bif.sim_exit_code_o, 8'h00);
      @(posedge clk); #1;
      lsu_read(32'h100, 32'hDEADBEEF, 1'b1);

`ifdef SIM_MEM_BRIDGE_CYCLE_CNT_EN
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      repeat (99) @(posedge clk);
      #1;
      bif.lsu_ce_i = 1'b1; bif.lsu_we_i = 1'b0; bif.lsu_addr_i = 32'h00020004;
      @(negedge clk);
      check("cnt_lo_range", (bif.lsu_data_o >= 32'd99) && (bif.lsu_data_o <= 32'd101), 1);
      check("cnt_ram_ce", bif.ram_ce_o, 0);
      @(posedge clk); #1 bif.lsu_addr_i = 32'h00020008;
      @(negedge clk);
      check("cnt_hi", bif.lsu_data_o, 32'h0);
      @(posedge clk); #1 bif.lsu_ce_i = 1'b0;
`else
      lsu_write(32'h00020004, 32'hCAFE0004, 4'hF, 1'b1);
      lsu_read(32'h00020004, 32'hCAFE0004, 1'b1);
`endif

      repeat (3) @(posedge clk);
      check("final_q_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
